// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and monitor FSM state type shared by the
// VGA frame monitor and its sync edge detectors.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_SYNC + H_BP + H_FP;
  localparam int unsigned H_START  = H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_SYNC + V_BP + V_FP;
  localparam int unsigned V_START  = V_SYNC + V_BP;

  localparam bit SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one VGA sync input and flags the cycle on which the registered
// level first reaches its asserted polarity.
module sync_edge_det #(
  parameter bit POL = vga_timing_pkg::SYNC_POL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic lead_o
);

  logic sync_q;
  logic prev_q;

  // Reset to the deasserted level so a sync already asserted at reset release
  // still produces a leading edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= ~POL;
      prev_q <= ~POL;
    end else begin
      sync_q <= sync_i;
      prev_q <= sync_q;
    end
  end

  assign lead_o = (sync_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: recovers pixel position from hsync/vsync, emits
// coordinate-tagged active pixels, checks timing, tracks lock, sums frames.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter bit          SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb565,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic        frame_ok,
  output logic        locked,
  output logic [7:0]  err_count
);

  import vga_timing_pkg::*;

  localparam logic [10:0] HTOT_M1 = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [10:0] HSTART  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HEND    = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  VTOT_M1 = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0]  VSTART  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEND    = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic        hs_lead;
  logic        vs_lead;
  logic [15:0] rgb_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic        line_err_q, line_err_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  err_d;
  mon_state_e  state_q, state_d;

  logic frame_start;
  logic line_bad;
  logic frame_bad;
  logic lines_ok;
  logic hsat;
  logic valid_d;
  logic fire;
  logic err_inc;

  sync_edge_det #(.POL(SYNC_POL)) u_hs_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (hsync),
    .lead_o (hs_lead)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vs_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (vsync),
    .lead_o (vs_lead)
  );

  // Counters are resolved combinationally in the stage-1 cycle so the pixel,
  // its coordinates and the frame results all register on the same edge.
  always_comb begin
    hcnt_d = hs_lead ? '0 : ((hcnt_q == '1) ? hcnt_q : hcnt_q + 11'd1);
    frame_start = hs_lead && (vs_pend_q || vs_lead);
    if (frame_start) begin
      vcnt_d = '0;
    end else if (hs_lead) begin
      vcnt_d = (vcnt_q == '1) ? vcnt_q : vcnt_q + 10'd1;
    end else begin
      vcnt_d = vcnt_q;
    end
    vs_pend_d = frame_start ? 1'b0 : (vs_lead ? 1'b1 : vs_pend_q);

    line_bad   = hs_lead && (hcnt_q != HTOT_M1);
    frame_bad  = (vcnt_q != VTOT_M1);
    lines_ok   = !line_err_q && !line_bad;
    line_err_d = frame_start ? 1'b0 : (line_err_q || line_bad);
    hsat       = (hcnt_d == '1);

    valid_d = (hcnt_d >= HSTART) && (hcnt_d < HEND) &&
              (vcnt_d >= VSTART) && (vcnt_d < VEND) && (state_q != SEARCH);
    fire    = frame_start && (state_q != SEARCH);

    acc_d = frame_start ? '0 : acc_q;
    if (valid_d) begin
      acc_d = acc_d + {16'h0000, rgb_q};
    end
  end

  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    case (state_q)
      SEARCH: begin
        if (frame_start) state_d = ALIGN;
      end
      ALIGN: begin
        if (line_bad) begin
          state_d = SEARCH;
        end else if (frame_start && lines_ok && !frame_bad) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || (frame_start && frame_bad) || hsat) begin
          state_d = SEARCH;
          err_inc = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
    err_d = (err_inc && (err_count != '1)) ? err_count + 8'd1 : err_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      vs_pend_q  <= 1'b0;
      line_err_q <= 1'b0;
      acc_q      <= '0;
      state_q    <= SEARCH;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_ok   <= 1'b0;
      err_count  <= '0;
    end else begin
      rgb_q      <= rgb565;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      vs_pend_q  <= vs_pend_d;
      line_err_q <= line_err_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      pix_valid  <= valid_d;
      pix_x      <= valid_d ? 10'(hcnt_d - HSTART) : '0;
      pix_y      <= valid_d ? (vcnt_d - VSTART) : '0;
      pix_data   <= valid_d ? rgb_q : '0;
      frame_done <= fire;
      if (fire) begin
        frame_sum <= acc_q;
        frame_ok  <= lines_ok && !frame_bad;
      end
      err_count  <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Receive-side counterpart of the game's VGA output: samples hsync/vsync/rgb565 on the pixel clock, recovers horizontal and vertical position, and re-emits active pixels as a coordinate-tagged stream. Also checks 640x480@60 timing, tracks lock, and produces a per-frame pixel checksum. It sits on the same clock as the VGA driver and taps its outputs, for self-check and for the frame-capture path.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, hsync width (clocks); H_BP 48; H_FP 16 (H total 800)
- V_ACTIVE, 480, active lines; V_SYNC 2; V_BP 33; V_FP 10 (V total 525)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock, one pixel per cycle
- rst_n  in  1  asynchronous active-low reset
- hsync, vsync  in  1  VGA syncs
- rgb565  in  16  pixel colour
- pix_valid  out  1  pix_* holds an active pixel
- pix_x, pix_y  out  10  active-area coordinates
- pix_data  out  16  pixel colour
- frame_done  out  1  one-cycle pulse, frame results updated
- frame_sum  out  32  sum of pix_data over the last frame, mod 2^32
- frame_ok  out  1  last frame had correct H and V totals
- locked  out  1  FSM in LOCKED
- err_count  out  8  saturating timing-error count

## Operation
- Stage 1 registers hsync, vsync, rgb565. Leading edge means the registered value goes to SYNC_POL from !SYNC_POL.
- hcnt (11 b): 0 on the hsync leading-edge cycle, else +1, saturating at 2047.
- At each hsync leading edge, line length = previous hcnt+1. It must equal 800.
- vs_pend is set by a vsync leading edge. On the next hsync leading edge (same cycle counts), vcnt becomes 0 and vs_pend clears. Otherwise vcnt increments on each hsync leading edge, saturating at 1023.
- At each frame start, frame length = previous vcnt+1. It must equal 525.
- Active pixel: hcnt in [144,784) and vcnt in [35,515). pix_x = hcnt−144, pix_y = vcnt−35.
- FSM states:
  - SEARCH: the reset state. Goes to ALIGN at the first frame start.
  - ALIGN: goes to LOCKED at the next frame start if every line length was 800 and the frame length was 525. On any bad line length, go to SEARCH.
  - LOCKED: on a bad line length, bad frame length, or hcnt saturation, go to SEARCH and increment err_count. This is the only err_count source; it saturates at 255.
- pix_valid = active pixel and state is not SEARCH.
- A running sum accumulates pix_data while pix_valid, mod 2^32.
- frame_done fires at a frame start when the state was ALIGN or LOCKED. On that pulse:
  - frame_sum and frame_ok latch.
  - The accumulator clears; the first pixel of the new frame is summed fresh.
  - frame_ok = 1 only if every line length and the frame length were correct.
- A frame start while in SEARCH clears the accumulator without a pulse.

## Timing
- Reset values: all outputs 0, state SEARCH, counters 0, vs_pend 0. Reset mid-frame discards the partial frame with no frame_done.
- Pixel latency: rgb565 sampled at edge k appears on pix_data after edge k+1 (two registers), with its matching pix_x/pix_y/pix_valid.
- frame_done, frame_sum, frame_ok, locked and err_count all update on the same edge, one cycle after the stage-1 hsync edge that starts the frame.
- Simultaneous events:
  - A vsync edge on the same cycle as an hsync edge counts as a frame start on that cycle.
  - A line-length error on a frame-start cycle goes to SEARCH and still emits frame_done with frame_ok = 0.

## Structure
- Shared package vga_timing_pkg holds:
  - 640x480 timing constants, including derived H_TOTAL=800, V_TOTAL=525, H_START=144, V_START=35;
  - FSM state enum {SEARCH, ALIGN, LOCKED}.
- One sub-module, sync_edge_det: input register plus polarity-aware leading-edge pulse; instantiated twice.

## Test plan
- Ideal 800x525 frames, constant 0xF800, from reset:
  - first frame_done at second frame start with frame_ok=1, frame_sum=0x8A800000;
  - locked=1 after that pulse;
  - err_count stays 0.
- Gradient pattern, rgb565 = hcnt−144 during the active area: pix_x=0, pix_y=0, pix_data=0x0000 appear 2 cycles after hcnt=144 on line 35; pix_valid is high for exactly 640 cycles per line.
- While LOCKED, one line is 799 clocks: locked drops at that hsync edge and err_count=1; relock follows after two clean frame starts.
- While LOCKED, hsync held deasserted 2100 clocks: SEARCH at hcnt=2047, err_count +1, pix_valid stays 0 until re-aligned.
- Frame of 524 lines while LOCKED: frame_done with frame_ok=0 and locked drops.
- rst_n pulsed low mid-frame while LOCKED: all outputs 0 immediately, no frame_done for the partial frame.
